// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Op codes, PSW bit positions, FSM/flag-mode enums and the
//               BCD digit adder shared by the alu_seq block.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDC = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SUBC = 5'b00110;
    localparam logic [4:0] OP_DADD = 5'b01000;
    localparam logic [4:0] OP_CMP  = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01100;
    localparam logic [4:0] OP_AND  = 5'b01110;
    localparam logic [4:0] OP_OR   = 5'b10000;
    localparam logic [4:0] OP_BIT  = 5'b10010;
    localparam logic [4:0] OP_BIC  = 5'b10100;
    localparam logic [4:0] OP_BIS  = 5'b10110;
    localparam logic [4:0] OP_SRA  = 5'b11000;
    localparam logic [4:0] OP_RRC  = 5'b11010;

    localparam int PSW_C = 0;
    localparam int PSW_Z = 1;
    localparam int PSW_N = 2;
    localparam int PSW_V = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        FM_NONE  = 3'd0,
        FM_ARITH = 3'd1,
        FM_LOGIC = 3'd2,
        FM_DADD  = 3'd3,
        FM_SHIFT = 3'd4
    } flag_mode_t;

    // Returns {cout, digit}; non-BCD inputs still wrap modulo 16.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a,
                                                 input logic [3:0] b,
                                                 input logic       cin);
        logic [4:0] t;
        logic [4:0] t_adj;
        t     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        t_adj = t - 5'd10;
        if (t > 5'd9) begin
            bcd_digit_add = {1'b1, t_adj[3:0]};
        end else begin
            bcd_digit_add = {1'b0, t[3:0]};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_flags.sv
`default_nettype none
// ============================================================================
// Module      : alu_flags
// Description : Combinational C/Z/N/V update for byte or word operand width.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flags
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PSW_W  = 16
) (
    input  logic              i_byte,
    input  flag_mode_t        i_mode,
    input  logic [DATA_W-1:0] i_res,
    input  logic              i_src_msb,
    input  logic              i_dst_msb,
    input  logic              i_carry,
    input  logic [PSW_W-1:0]  i_psw,
    output logic [PSW_W-1:0]  o_psw
);

    logic w_res_msb;
    logic w_zero;
    logic w_ovf;

    always_comb begin
        w_res_msb = i_byte ? i_res[7] : i_res[DATA_W-1];
        w_zero    = i_byte ? (i_res[7:0] == 8'd0) : (i_res == '0);
        w_ovf     = (i_src_msb == i_dst_msb) && (w_res_msb != i_src_msb);

        o_psw = i_psw;
        case (i_mode)
            FM_ARITH: begin
                o_psw[PSW_C] = i_carry;
                o_psw[PSW_Z] = w_zero;
                o_psw[PSW_N] = w_res_msb;
                o_psw[PSW_V] = w_ovf;
            end
            FM_LOGIC: begin
                o_psw[PSW_Z] = w_zero;
                o_psw[PSW_N] = w_res_msb;
            end
            FM_DADD: begin
                o_psw[PSW_C] = i_carry;
                o_psw[PSW_Z] = w_zero;
            end
            FM_SHIFT: begin
                o_psw[PSW_C] = i_carry;
                o_psw[PSW_Z] = w_zero;
                o_psw[PSW_N] = w_res_msb;
                o_psw[PSW_V] = 1'b0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle ALU with valid/ready handshake, iterative BCD add
//               and shift/rotate by count.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PSW_W  = 16
) (
    input  logic              E,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        instr,
    input  logic              instr_opt,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  logic [PSW_W-1:0]  PSW_i,
    output logic [DATA_W-1:0] result,
    output logic [PSW_W-1:0]  PSW_o,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int                CNT_W     = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              cy_q, cy_d;
    logic [4:0]        op_q, op_d;
    logic              byte_q, byte_d;
    logic              opt_q, opt_d;
    logic [PSW_W-1:0]  psw_q, psw_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [PSW_W-1:0]  psw_o_q, psw_o_d;

    function automatic logic [DATA_W-1:0] merge_low(input logic [DATA_W-1:0] hi,
                                                    input logic [7:0]        lo);
        return (hi & ~BYTE_MASK) | DATA_W'(lo);
    endfunction

    logic [4:0]        w_op;
    logic              w_sub, w_cin, w_multi;
    logic [DATA_W-1:0] w_src, w_arith, w_lmax, w_idx, w_mask, w_logic_raw, w_logic;
    logic [DATA_W:0]   w_sum_w;
    logic [8:0]        w_sum_b;
    logic              w_arith_c;
    logic [CNT_W-1:0]  w_n, w_len, w_n_sat, w_digits;
    logic [DATA_W-1:0] w_single_res, w_single_fres;
    flag_mode_t        w_single_mode;
    logic              w_single_c;

    // Accept-time datapath: everything that completes in a single cycle.
    always_comb begin
        w_op  = {instr[4:1], 1'b0};
        w_sub = (w_op == OP_SUB) || (w_op == OP_SUBC) || (w_op == OP_CMP);
        w_src = w_sub ? ~op2 : op2;
        case (w_op)
            OP_ADD:         w_cin = 1'b0;
            OP_SUB, OP_CMP: w_cin = 1'b1;
            default:        w_cin = PSW_i[PSW_C];
        endcase
        w_sum_w   = {1'b0, op1} + {1'b0, w_src} + {{DATA_W{1'b0}}, w_cin};
        w_sum_b   = {1'b0, op1[7:0]} + {1'b0, w_src[7:0]} + {8'd0, w_cin};
        w_arith   = instr[0] ? merge_low(op1, w_sum_b[7:0]) : w_sum_w[DATA_W-1:0];
        w_arith_c = instr[0] ? w_sum_b[8] : w_sum_w[DATA_W];

        w_lmax = instr[0] ? DATA_W'(7) : DATA_W'(DATA_W - 1);
        w_idx  = (op2 > w_lmax) ? w_lmax : op2;
        w_mask = {{(DATA_W-1){1'b0}}, 1'b1} << w_idx;
        case (w_op)
            OP_XOR:  w_logic_raw = op1 ^ op2;
            OP_AND:  w_logic_raw = op1 & op2;
            OP_OR:   w_logic_raw = op1 | op2;
            OP_BIT:  w_logic_raw = op1 & w_mask;
            OP_BIC:  w_logic_raw = op1 & ~w_mask;
            default: w_logic_raw = op1 | w_mask;
        endcase
        w_logic = instr[0] ? merge_low(op1, w_logic_raw[7:0]) : w_logic_raw;

        w_n      = CNT_W'(op2[3:0]);
        w_len    = instr[0] ? CNT_W'(8) : CNT_W'(DATA_W);
        w_n_sat  = (w_n > w_len) ? w_len : w_n;
        w_digits = instr[0] ? CNT_W'(2) : CNT_W'(DATA_W / 4);
        w_multi  = (w_op == OP_DADD) ||
                   (((w_op == OP_SRA) || (w_op == OP_RRC)) && (w_n_sat != '0));

        w_single_res  = op1;
        w_single_fres = op1;
        w_single_mode = FM_NONE;
        w_single_c    = PSW_i[PSW_C];
        case (w_op)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
                w_single_res  = w_arith;
                w_single_fres = w_arith;
                w_single_mode = FM_ARITH;
                w_single_c    = w_arith_c;
            end
            OP_CMP: begin
                w_single_fres = w_arith;
                w_single_mode = FM_ARITH;
                w_single_c    = w_arith_c;
            end
            OP_XOR, OP_AND, OP_OR, OP_BIT, OP_BIC, OP_BIS: begin
                w_single_res  = w_logic;
                w_single_fres = w_logic;
                w_single_mode = FM_LOGIC;
            end
            OP_SRA, OP_RRC: w_single_mode = FM_SHIFT;
            default: ;
        endcase
    end

    logic [4:0]        w_dig;
    logic              w_top, w_step_c;
    logic [DATA_W-1:0] w_dadd_step, w_shift_step, w_step_res;

    // One BCD digit or one bit position per EXEC cycle, rotating within L bits.
    always_comb begin
        w_dig        = bcd_digit_add(a_q[3:0], b_q[3:0], cy_q);
        w_dadd_step  = byte_q ? merge_low(a_q, {w_dig[3:0], a_q[7:4]})
                              : {w_dig[3:0], a_q[DATA_W-1:4]};
        w_top        = (op_q == OP_RRC) ? cy_q : (byte_q ? a_q[7] : a_q[DATA_W-1]);
        w_shift_step = byte_q ? merge_low(a_q, {w_top, a_q[7:1]})
                              : {w_top, a_q[DATA_W-1:1]};
        w_step_res   = (op_q == OP_DADD) ? w_dadd_step : w_shift_step;
        w_step_c     = (op_q == OP_DADD) ? w_dig[4] : a_q[0];
    end

    logic              w_fl_byte, w_fl_src_msb, w_fl_dst_msb, w_fl_carry;
    flag_mode_t        w_fl_mode;
    logic [DATA_W-1:0] w_fl_res;
    logic [PSW_W-1:0]  w_fl_psw_in, w_fl_psw;

    always_comb begin
        if (state_q == ST_IDLE) begin
            w_fl_byte    = instr[0];
            w_fl_res     = w_single_fres;
            w_fl_src_msb = instr[0] ? w_src[7] : w_src[DATA_W-1];
            w_fl_dst_msb = instr[0] ? op1[7] : op1[DATA_W-1];
            w_fl_carry   = w_single_c;
            w_fl_mode    = instr_opt ? w_single_mode : FM_NONE;
            w_fl_psw_in  = PSW_i;
        end else begin
            w_fl_byte    = byte_q;
            w_fl_res     = w_step_res;
            w_fl_src_msb = 1'b0;
            w_fl_dst_msb = 1'b0;
            w_fl_carry   = w_step_c;
            w_fl_mode    = !opt_q ? FM_NONE : ((op_q == OP_DADD) ? FM_DADD : FM_SHIFT);
            w_fl_psw_in  = psw_q;
        end
    end

    alu_flags #(
        .DATA_W (DATA_W),
        .PSW_W  (PSW_W)
    ) u_flags (
        .i_byte    (w_fl_byte),
        .i_mode    (w_fl_mode),
        .i_res     (w_fl_res),
        .i_src_msb (w_fl_src_msb),
        .i_dst_msb (w_fl_dst_msb),
        .i_carry   (w_fl_carry),
        .i_psw     (w_fl_psw_in),
        .o_psw     (w_fl_psw)
    );

    always_ff @(posedge E) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cy_q     <= 1'b0;
            op_q     <= '0;
            byte_q   <= 1'b0;
            opt_q    <= 1'b0;
            psw_q    <= '0;
            result_q <= '0;
            psw_o_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cy_q     <= cy_d;
            op_q     <= op_d;
            byte_q   <= byte_d;
            opt_q    <= opt_d;
            psw_q    <= psw_d;
            result_q <= result_d;
            psw_o_q  <= psw_o_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = w_multi ? ST_EXEC : ST_DONE;
            ST_EXEC: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter is loaded with (steps - 1); the last step also writes the result.
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        cy_d     = cy_q;
        op_d     = op_q;
        byte_d   = byte_q;
        opt_d    = opt_q;
        psw_d    = psw_q;
        result_d = result_q;
        psw_o_d  = psw_o_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d    = op1;
                    b_d    = op2;
                    cy_d   = PSW_i[PSW_C];
                    op_d   = w_op;
                    byte_d = instr[0];
                    opt_d  = instr_opt;
                    psw_d  = PSW_i;
                    if (w_multi) begin
                        cnt_d = ((w_op == OP_DADD) ? w_digits : w_n_sat) - CNT_W'(1);
                    end else begin
                        cnt_d    = '0;
                        result_d = w_single_res;
                        psw_o_d  = w_fl_psw;
                    end
                end
            end
            ST_EXEC: begin
                a_d  = w_step_res;
                b_d  = b_q >> 4;
                cy_d = w_step_c;
                if (cnt_q == '0) begin
                    result_d = w_step_res;
                    psw_o_d  = w_fl_psw;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        result    = result_q;
        PSW_o     = psw_o_q;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the basic CPU ALU. It executes the two-operand arithmetic/logic set at DATA_W bits, with a byte mode on bit 0 of the op code. It adds two iterative operations: a full multi-digit BCD add with a correct digit-carry chain, and shifts/rotates by a count. It sits between register-file read and writeback and uses a valid/ready handshake, so the control unit can stall on multi-cycle ops.

## Interface
- DATA_W, 16, operand/result width; multiple of 8, minimum 8
- PSW_W, 16, PSW width; bits C=0, Z=1, N=2, V=4; all other bits pass through unchanged
- E  input  1  clock; all state updates on posedge E
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept (IDLE only)
- instr  input  5  op code; bit0 = byte mode (.b)
- instr_opt  input  1  1 = update PSW flags; 0 = psw_o equals psw_i captured at accept
- op1  input  DATA_W  dst operand
- op2  input  DATA_W  src operand, or shift count in op2[3:0]
- PSW_i  input  PSW_W  PSW at accept; C = PSW_i[0]
- result  output  DATA_W  registered result
- PSW_o  output  PSW_W  registered PSW
- out_valid  output  1  result/PSW_o valid; held until out_ready
- out_ready  input  1  consumer accepts

## Operation
- Op codes (bit0 = .b):
  - 00000 add, 00010 addc, 00100 sub, 00110 subc, 01000 dadd, 01010 cmp
  - 01100 xor, 01110 and, 10000 or, 10010 bit, 10100 bic, 10110 bis
  - 11000 sra, 11010 rrc
  - Unused codes: result = op1, PSW unchanged, single-cycle.
- Operand width L = 8 in byte mode, else DATA_W. In byte mode, result[DATA_W-1:8] = op1[DATA_W-1:8].
- Subtraction: sub = op1 + ~op2 + 1; subc = op1 + ~op2 + C. C = carry out of bit L-1 (1 = no borrow).
- Arithmetic flags: V = (s==d) & (r!=s) on the L-1 MSBs; N = r[L-1]; Z = (r[L-1:0]==0).
- cmp: flags as for sub; result = op1.
- Logic ops (xor, and, or, bit, bic, bis): update N and Z only; C and V unchanged.
- bit/bic/bis: bit index = op2, saturated to L-1. bit returns op1 & mask.
- dadd:
  - One BCD digit per cycle, LSB first; L/4 digits; carry-in = C.
  - Per digit: t = a + b + cin; if t>9 then digit = t-10 (mod 16), cout = 1.
  - Final cout sets C; Z is set over L bits; N and V unchanged.
- sra/rrc:
  - One bit position per cycle, n = op2[3:0] saturated to L.
  - sra replicates bit L-1.
  - rrc: each step moves C into bit L-1 and bit 0 into C.
  - N and Z are set on the final value; V = 0.
  - n = 0: result = op1 and C unchanged.
- FSM states:
  - IDLE → EXEC (dadd, or shift with n>0) or → DONE (all other ops) on in_valid & in_ready.
  - EXEC → DONE when the digit/step counter reaches its terminal value.
  - DONE → IDLE on out_ready.

## Timing
- Reset values: result = 0, PSW_o = 0, out_valid = 0, in_ready = 1, state IDLE, counter 0.
- rst during any state aborts the operation; the reset values appear the next cycle.
- Single-cycle ops: out_valid is asserted on the cycle after accept.
- dadd: out_valid rises L/4 + 1 cycles after accept (word: 5, byte: 3).
- Shifts: out_valid rises n + 1 cycles after accept (n=0: 1).
- in_ready is low from accept until out_valid & out_ready.
- A new request cannot be accepted in the same cycle as out_ready; at most one op is in flight.
- result and PSW_o are stable while out_valid is high and stall-safe indefinitely.
- Inputs are sampled only at accept; later changes to op1, op2, PSW_i or instr have no effect.

## Structure
- Package alu_pkg:
  - op code localparams
  - PSW bit index constants (PSW_C, PSW_Z, PSW_N, PSW_V)
  - FSM state enum
  - function bcd_digit_add(a, b, cin) returning {cout, digit}
- Sub-module alu_flags: combinational V/C/N/Z generation for L and mode. It is instantiated once and shared by arithmetic, logic and shift completion.
- The top level holds the FSM, operand/result shift registers, and the digit/step counter sized $clog2(DATA_W+1).

## Test plan
- add word: op1=0x7FFF, op2=0x0001, instr_opt=1 → result 0x8000; V=1, N=1, Z=0, C=0; out_valid 1 cycle after accept.
- sub.b: op1=0xAB10, op2=0x0010 → result 0xAB00; Z=1, C=1, N=0, V=0; upper byte preserved.
- dadd word:
  - Case 1: op1=0x0999, op2=0x0001, C=0 → result 0x1000, C=0; out_valid after 5 cycles.
  - Case 2: op1=0x9999, op2=0x0001 → result 0x0000, C=1, Z=1.
- rrc word: op1=0x0003, n=2, C=1 → result 0xC000, C=1, N=1; n=0 → op1 returned and C unchanged in 1 cycle.
- Backpressure/reset:
  - Hold out_ready=0 for 10 cycles: result, PSW_o and out_valid are stable; in_ready stays 0.
  - Assert rst mid-dadd: the next cycle shows out_valid=0, result=0, in_ready=1.
- instr_opt=0: an add with overflow leaves PSW_o = PSW_i (e.g. 0x0015 in → 0x0015 out).
